jericalla_seq: RTL

Program sequencer for the jericalla datapath. Holds a 16-slot program of 17-bit jericalla instructions loaded through a write port. On `start` it issues the program one instruction per clock onto jericalla's `instruction` input, then signals completion. Sits directly in front of jericalla and consumes its `z_flag` for optional conditional skipping.

---
 rtl/jericalla_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/jericalla_seq.sv
// jericalla_seq: program sequencer sitting in front of the jericalla datapath.
// Holds a 16-slot program of 17-bit instructions written through a load port.
// On start it issues `length` instructions, one per clock, then pulses done.
// Optional feature macro: JERICALLA_SEQ_ZSKIP_EN. When it is defined, a high
// z_flag during a RUN cycle skips the following program slot.
module jericalla_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [3:0]  load_addr,
  input  logic [16:0] load_instr,
  input  logic        start,
  input  logic [4:0]  length,
  input  logic        abort,
  input  logic        z_flag,
  output logic [16:0] instruction,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        done
);

  localparam int DEPTH = 16;
  localparam int IW    = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    pc_nxt;
  logic [4:0]    count;
  logic [4:0]    count_nxt;
  logic [4:0]    len;
  logic [4:0]    len_nxt;
  logic [1:0]    step;
  logic [5:0]    advanced;
  logic          load_ok;
  logic [IW-1:0] prog [DEPTH];

`ifdef JERICALLA_SEQ_ZSKIP_EN
  // A zero result on the current instruction makes the next slot a no-show.
  assign step = z_flag ? 2'd2 : 2'd1;
`else
  // Without skipping every RUN cycle advances by exactly one slot.
  assign step = 2'd1;
  logic unused_z_flag;
  assign unused_z_flag = z_flag;
`endif

  // Issued count after this cycle; one extra bit so count + 2 cannot wrap.
  assign advanced = {1'b0, count} + {4'b0000, step};

  // The program may only change while no run is in flight.
  assign load_ok = load_en && (state != RUN);

  // Program storage has no reset so a reset mid-run keeps the loaded program.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      prog[load_addr] <= load_instr;
    end
  end

  // State, program counter, issued count and latched run length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= 4'd0;
      count <= 5'd0;
      len   <= 5'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      len   <= len_nxt;
    end
  end

  // Next-state logic; abort wins over completion, start is only seen in IDLE.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    len_nxt   = len;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != 5'd0) begin
            state_nxt = RUN;
            pc_nxt    = 4'd0;
            count_nxt = 5'd0;
            len_nxt   = length;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (advanced >= {1'b0, len}) begin
          state_nxt = DONE;
        end else begin
          pc_nxt    = pc + {2'b00, step};
          count_nxt = advanced[4:0];
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode from the state register, so reset clears them at once.
  always_comb begin
    instruction = '0;
    busy        = 1'b0;
    done        = 1'b0;
    if (state == RUN) begin
      instruction = prog[pc];
      busy        = 1'b1;
    end
    if (state == DONE) begin
      done = 1'b1;
    end
  end

endmodule
